// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Bundles every handshake and datapath signal of alu_arbiter.
//   req0/req1 : request channel (valid/ready, op, operands a/b)
//   rsp0/rsp1 : response channel (valid/ready, result, zero, err)
//   alu_*     : registered operands/op towards the shared ALU and its
//               combinational result/zero flag coming back
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding environment (both requesters plus the ALU)
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_result;
    logic             rsp0_zero;
    logic             rsp0_err;

    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_result;
    logic             rsp1_zero;
    logic             rsp1_err;

    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
        input  rsp0_ready,
        output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
        input  rsp1_ready,
        output alu_in1, alu_in2, alu_control,
        input  alu_result, alu_zero
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
        output rsp0_ready,
        input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
        output rsp1_ready,
        input  alu_in1, alu_in2, alu_control,
        output alu_result, alu_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external combinational ALU between two requesters. A request
// is granted round-robin, its op/operands are registered onto the ALU, the
// result and zero flag are captured one cycle later and returned on the
// owner's response channel. One operation is in flight at a time.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_arbiter_if.slave (request, response and ALU signals)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; ready offered to the granted requester
// EXEC  | ALU settling on registered operands; result captured at edge
// RESP  | response valid to owner, held until the owner takes it
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MAX = 4'b1001;

    state_t           state;
    logic             rr_ptr;
    logic             owner;
    logic             err_pend;

    logic [WIDTH-1:0] alu_in1_q;
    logic [WIDTH-1:0] alu_in2_q;
    logic [3:0]       alu_control_q;

    logic             rsp0_valid_q;
    logic [WIDTH-1:0] rsp0_result_q;
    logic             rsp0_zero_q;
    logic             rsp0_err_q;
    logic             rsp1_valid_q;
    logic [WIDTH-1:0] rsp1_result_q;
    logic             rsp1_zero_q;
    logic             rsp1_err_q;

    logic             grant;
    logic             accept;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // rr_ptr only breaks ties; a lone requester is always granted.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = rr_ptr;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready depends on valid so an idle block with no requests shows ready=0.
    assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !grant;
    assign bus.req1_ready = (state == IDLE) && bus.req1_valid && grant;
    assign accept         = bus.req0_ready || bus.req1_ready;

    assign sel_op = grant ? bus.req1_op : bus.req0_op;
    assign sel_a  = grant ? bus.req1_a  : bus.req0_a;
    assign sel_b  = grant ? bus.req1_b  : bus.req0_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= 1'b0;
            owner         <= 1'b0;
            err_pend      <= 1'b0;
            alu_in1_q     <= '0;
            alu_in2_q     <= '0;
            alu_control_q <= 4'b0000;
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp0_err_q    <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_zero_q   <= 1'b0;
            rsp1_err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner  <= grant;
                        rr_ptr <= ~grant;
                        if (sel_op <= OP_MAX) begin
                            alu_control_q <= sel_op;
                            alu_in1_q     <= sel_a;
                            alu_in2_q     <= sel_b;
                            err_pend      <= 1'b0;
                        end else begin
                            // Unsupported code: park the ALU on a harmless
                            // 0+0 and remember to flag the response.
                            alu_control_q <= OP_ADD;
                            alu_in1_q     <= '0;
                            alu_in2_q     <= '0;
                            err_pend      <= 1'b1;
                        end
                        state <= EXEC;
                    end
                end

                EXEC: begin
                    // Error responses are forced rather than taken from the
                    // ALU so they do not depend on the external ALU's 0+0.
                    if (!owner) begin
                        rsp0_result_q <= err_pend ? '0 : bus.alu_result;
                        rsp0_zero_q   <= err_pend ? 1'b1 : bus.alu_zero;
                        rsp0_err_q    <= err_pend;
                        rsp0_valid_q  <= 1'b1;
                    end else begin
                        rsp1_result_q <= err_pend ? '0 : bus.alu_result;
                        rsp1_zero_q   <= err_pend ? 1'b1 : bus.alu_zero;
                        rsp1_err_q    <= err_pend;
                        rsp1_valid_q  <= 1'b1;
                    end
                    state <= RESP;
                end

                RESP: begin
                    if (!owner && bus.rsp0_ready) begin
                        rsp0_valid_q <= 1'b0;
                        state        <= IDLE;
                    end else if (owner && bus.rsp1_ready) begin
                        rsp1_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_in1     = alu_in1_q;
    assign bus.alu_in2     = alu_in2_q;
    assign bus.alu_control = alu_control_q;

    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp0_result = rsp0_result_q;
    assign bus.rsp0_zero   = rsp0_zero_q;
    assign bus.rsp0_err    = rsp0_err_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp1_result = rsp1_result_q;
    assign bus.rsp1_zero   = rsp1_zero_q;
    assign bus.rsp1_err    = rsp1_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed requests, expected responses queued
// per port at issue time and checked by an independent negedge monitor.
module tb_alu_arbiter;

    logic clk;
    logic rst_n;

    alu_arbiter_if #(.WIDTH(32)) bus ();

    alu_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU driven from the arbiter's registered outputs.
    logic [31:0] alu_r;
    always_comb begin
        alu_r = 32'd0;
        case (bus.alu_control)
            4'b0000: alu_r = bus.alu_in1 & bus.alu_in2;
            4'b0001: alu_r = bus.alu_in1 | bus.alu_in2;
            4'b0010: alu_r = bus.alu_in1 + bus.alu_in2;
            4'b0011: alu_r = bus.alu_in1 << bus.alu_in2[4:0];
            4'b0100: alu_r = bus.alu_in1 - bus.alu_in2;
            4'b0101: alu_r = bus.alu_in1 >> bus.alu_in2[4:0];
            4'b0110: alu_r = bus.alu_in1 * bus.alu_in2;
            4'b0111: alu_r = bus.alu_in1 ^ bus.alu_in2;
            4'b1000: alu_r = {31'd0, (bus.alu_in1 < bus.alu_in2)};
            4'b1001: alu_r = $signed(bus.alu_in1) >>> bus.alu_in2[4:0];
            default: alu_r = 32'd0;
        endcase
    end
    assign bus.alu_result = alu_r;
    assign bus.alu_zero   = (alu_r == 32'd0);

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        e;
    } exp_t;

    exp_t exp0_q[$];
    exp_t exp1_q[$];
    int   grant_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = -1;
    bit gap_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: grant order, accept spacing, and response scoreboard.
    exp_t mon_e;
    int   mon_g;
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
                if (grant_q.size() == 0) begin
                    chk("unexpected_grant", 32'd1, 32'd0);
                end else begin
                    mon_g = grant_q.pop_front();
                    chk("grant_port", {31'd0, bus.req1_ready}, mon_g);
                end
                if (gap_chk) begin
                    if (last_acc >= 0) chk("accept_gap", cyc - last_acc, 32'd3);
                    last_acc = cyc;
                end
            end
            if (bus.rsp0_valid && bus.rsp0_ready) begin
                if (exp0_q.size() == 0) begin
                    chk("unexpected_rsp0", 32'd1, 32'd0);
                end else begin
                    mon_e = exp0_q.pop_front();
                    chk("rsp0_result", bus.rsp0_result, mon_e.res);
                    chk("rsp0_zero", {31'd0, bus.rsp0_zero}, {31'd0, mon_e.z});
                    chk("rsp0_err", {31'd0, bus.rsp0_err}, {31'd0, mon_e.e});
                end
            end
            if (bus.rsp1_valid && bus.rsp1_ready) begin
                if (exp1_q.size() == 0) begin
                    chk("unexpected_rsp1", 32'd1, 32'd0);
                end else begin
                    mon_e = exp1_q.pop_front();
                    chk("rsp1_result", bus.rsp1_result, mon_e.res);
                    chk("rsp1_zero", {31'd0, bus.rsp1_zero}, {31'd0, mon_e.z});
                    chk("rsp1_err", {31'd0, bus.rsp1_err}, {31'd0, mon_e.e});
                end
            end
            if (bus.rsp0_valid && bus.rsp1_valid) chk("single_rsp_valid", 32'd1, 32'd0);
        end
    end

    task automatic issue(input int port, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ez,
                         input logic ee);
        exp_t e;
        bit   accepted;
        e.res = er;
        e.z   = ez;
        e.e   = ee;
        accepted = 1'b0;
        if (port == 0) begin
            exp0_q.push_back(e);
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end else begin
            exp1_q.push_back(e);
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (port == 0 ? bus.req0_ready : bus.req1_ready) accepted = 1'b1;
        end
        if (!accepted) chk("accept_timeout", {31'd0, accepted}, 32'd1);
        @(posedge clk);
        #1;
        if (port == 0) bus.req0_valid = 1'b0;
        else           bus.req1_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
        chk("rst_rsp0_result", bus.rsp0_result, 32'd0);
        chk("rst_rsp1_result", bus.rsp1_result, 32'd0);
        chk("rst_rsp0_zero", {31'd0, bus.rsp0_zero}, 32'd0);
        chk("rst_rsp1_zero", {31'd0, bus.rsp1_zero}, 32'd0);
        chk("rst_rsp0_err", {31'd0, bus.rsp0_err}, 32'd0);
        chk("rst_rsp1_err", {31'd0, bus.rsp1_err}, 32'd0);
        chk("rst_alu_in1", bus.alu_in1, 32'd0);
        chk("rst_alu_in2", bus.alu_in2, 32'd0);
        chk("rst_alu_control", {28'd0, bus.alu_control}, 32'd0);
        chk("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    endtask

    task automatic wait_rsp0_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.rsp0_valid) seen = 1'b1;
        end
        chk("rsp0_valid_seen", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (errors so far %0d)", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_op = 4'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
        bus.req1_valid = 1'b0; bus.req1_op = 4'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #2;
        check_reset_vals();
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD 5+7 on req0, latency and idle port checks
        grant_q.push_back(0);
        issue(0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        chk("t1_alu_control", {28'd0, bus.alu_control}, 32'h2);
        chk("t1_alu_in1", bus.alu_in1, 32'd5);
        chk("t1_alu_in2", bus.alu_in2, 32'd7);
        @(negedge clk);
        chk("t1_rsp0_valid_exec", {31'd0, bus.rsp0_valid}, 32'd0);
        @(negedge clk);
        chk("t1_rsp0_valid_resp", {31'd0, bus.rsp0_valid}, 32'd1);
        chk("t1_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Fresh reset, then both ports valid together
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 check_reset_vals();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        grant_q.push_back(0);
        grant_q.push_back(1);
        gap_chk = 1'b1;
        last_acc = -1;
        fork
            issue(0, 4'b0100, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
            issue(1, 4'b0001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
        join
        gap_chk = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Continuous contention: strict alternation
        for (int k = 0; k < 3; k++) begin
            grant_q.push_back(0);
            grant_q.push_back(1);
        end
        gap_chk = 1'b1;
        last_acc = -1;
        fork
            begin
                issue(0, 4'b0010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
                issue(0, 4'b0111, 32'hFF, 32'h0F, 32'hF0, 1'b0, 1'b0);
                issue(0, 4'b0110, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
            end
            begin
                issue(1, 4'b0100, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0);
                issue(1, 4'b0101, 32'h80, 32'd3, 32'h10, 1'b0, 1'b0);
                issue(1, 4'b1000, 32'd3, 32'd5, 32'd1, 1'b0, 1'b0);
            end
        join
        gap_chk = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Response backpressure on port 0 with req1 pending
        bus.rsp0_ready = 1'b0;
        grant_q.push_back(0);
        grant_q.push_back(1);
        fork
            issue(0, 4'b0000, 32'hFF00, 32'h0FF0, 32'h0F00, 1'b0, 1'b0);
            begin
                @(posedge clk);
                #1;
                issue(1, 4'b1001, 32'hFFFF_FF00, 32'd4, 32'hFFFF_FFF0, 1'b0, 1'b0);
            end
            begin
                wait_rsp0_valid();
                for (int k = 0; k < 4; k++) begin
                    if (k > 0) @(negedge clk);
                    chk("bp_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
                    chk("bp_rsp0_result", bus.rsp0_result, 32'h0F00);
                    chk("bp_rsp0_zero", {31'd0, bus.rsp0_zero}, 32'd0);
                    chk("bp_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
                end
                @(posedge clk);
                #1 bus.rsp0_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Unsupported op on req1
        grant_q.push_back(1);
        issue(1, 4'b1100, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1);
        chk("err_alu_control", {28'd0, bus.alu_control}, 32'h2);
        chk("err_alu_in1", bus.alu_in1, 32'd0);
        chk("err_alu_in2", bus.alu_in2, 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // Reset while holding a response, then recover
        bus.rsp0_ready = 1'b0;
        grant_q.push_back(0);
        issue(0, 4'b0000, 32'hF, 32'h3, 32'h3, 1'b0, 1'b0);
        wait_rsp0_valid();
        #2 rst_n = 1'b0;
        #1;
        chk("rr_rsp0_valid_drop", {31'd0, bus.rsp0_valid}, 32'd0);
        check_reset_vals();
        exp0_q.delete();
        #1 rst_n = 1'b1;
        bus.rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        grant_q.push_back(0);
        issue(0, 4'b0011, 32'd1, 32'd4, 32'd16, 1'b0, 1'b0);

        for (int i = 0; i < 50; i++) begin
            if (exp0_q.size() == 0 && exp1_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("drain_exp0", exp0_q.size(), 32'd0);
        chk("drain_exp1", exp1_q.size(), 32'd0);
        chk("drain_grants", grant_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
